ex_div: RTL and testbench



---
 rtl/ex_div.sv | 165 ++++++++++++++++
 tb/tb_ex_div.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// ex_div: iterative RV32M divider sitting in the EX stage behind ID/EX.
// Executes DIV/DIVU/REM/REMU with a 32-step restoring algorithm on operand
// magnitudes, applies the RISC-V sign rules afterwards, and stalls the
// front pipeline through div_hold_o while a division is in flight.
//
// Ports:
//   clk_100MHz    core clock, rising edge
//   rst           synchronous active-high reset
//   start_i       division request from ID/EX
//   op_i          funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i    rs1 data
//   divisor_i     rs2 data
//   reg_w_addr_i  destination register
//   jump_ena_i    flush; aborts any operation
//   div_hold_o    stall request to ID/EX
//   busy_o        FSM not idle
//   ready_o       one-cycle result strobe
//   result_o      quotient or remainder, held between strobes
//   reg_w_ena_o   write enable, same as ready_o
//   reg_w_addr_o  destination of the result on result_o
//
// state | meaning
// IDLE  | waiting for an accepted start
// CALC  | restoring iterations, one quotient bit per clock
// DONE  | sign correction, result register load, ready strobe
module ex_div #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_100MHz,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      reg_w_addr_i,
  input  logic            jump_ena_i,
  output logic            div_hold_o,
  output logic            busy_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o,
  output logic            reg_w_ena_o,
  output logic [4:0]      reg_w_addr_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic              op_rem_q;
  logic              sign_a_q, sign_b_q;
  logic              special_q;
  logic [4:0]        addr_q;
  logic [XLEN-1:0]   quot_q, rem_q, div_mag_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              signed_op;
  logic              div_zero, sgn_ovf, special;
  logic              start_ok;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     rem_sh, diff;
  logic [XLEN-1:0]   q_fix, r_fix;

  assign signed_op = ~op_i[0];
  assign div_zero  = (divisor_i == '0);
  assign sgn_ovf   = signed_op && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                     && (divisor_i == '1);
  assign special   = div_zero | sgn_ovf;

  // ready_o blocks acceptance because the finished instruction is still in
  // ID/EX during the strobe cycle and would otherwise be issued twice.
  assign start_ok  = (state_q == IDLE) & start_i & ~jump_ena_i & ~ready_o;

  assign mag_a = (signed_op & dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
  assign mag_b = (signed_op & divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;

  // Remainder can reach divisor-1 before the shift, so the trial needs one
  // extra bit to hold the shifted value without overflow.
  assign rem_sh = {rem_q, quot_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, div_mag_q};

  // Special-case results are final when loaded, so they skip sign fixing.
  assign q_fix = (special_q | ~(sign_a_q ^ sign_b_q)) ? quot_q : -quot_q;
  assign r_fix = (special_q | ~sign_a_q) ? rem_q : -rem_q;

  assign busy_o      = (state_q != IDLE);
  assign div_hold_o  = busy_o | (start_i & ~ready_o & ~jump_ena_i);
  assign reg_w_ena_o = ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = special ? DONE : CALC;
      CALC:    if (cnt_q == CNT_W'(XLEN-1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (jump_ena_i) state_d = IDLE;
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      op_rem_q     <= 1'b0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      special_q    <= 1'b0;
      addr_q       <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      div_mag_q    <= '0;
      cnt_q        <= '0;
      ready_o      <= 1'b0;
      result_o     <= '0;
      reg_w_addr_o <= '0;
    end else begin
      ready_o <= 1'b0;
      if (!jump_ena_i) begin
        case (state_q)
          IDLE: begin
            if (start_ok) begin
              op_rem_q  <= op_i[1];
              sign_a_q  <= signed_op & dividend_i[XLEN-1];
              sign_b_q  <= signed_op & divisor_i[XLEN-1];
              special_q <= special;
              addr_q    <= reg_w_addr_i;
              div_mag_q <= mag_b;
              cnt_q     <= '0;
              if (div_zero) begin
                quot_q <= '1;
                rem_q  <= dividend_i;
              end else if (sgn_ovf) begin
                quot_q <= {1'b1, {(XLEN-1){1'b0}}};
                rem_q  <= '0;
              end else begin
                quot_q <= mag_a;
                rem_q  <= '0;
              end
            end
          end
          CALC: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (!diff[XLEN]) begin
              rem_q  <= diff[XLEN-1:0];
              quot_q <= {quot_q[XLEN-2:0], 1'b1};
            end else begin
              rem_q  <= rem_sh[XLEN-1:0];
              quot_q <= {quot_q[XLEN-2:0], 1'b0};
            end
          end
          DONE: begin
            result_o     <= op_rem_q ? r_fix : q_fix;
            reg_w_addr_o <= addr_q;
            ready_o      <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_div.sv
module tb_ex_div;

  logic        clk_100MHz = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  reg_w_addr_i = '0;
  logic        jump_ena_i = 1'b0;
  logic        div_hold_o, busy_o, ready_o, reg_w_ena_o;
  logic [31:0] result_o;
  logic [4:0]  reg_w_addr_o;

  int n_total = 0;
  int n_pass  = 0;

  ex_div #(.XLEN(32), .CNT_W(5)) dut (
    .clk_100MHz  (clk_100MHz),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .reg_w_addr_i(reg_w_addr_i),
    .jump_ena_i  (jump_ena_i),
    .div_hold_o  (div_hold_o),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .result_o    (result_o),
    .reg_w_ena_o (reg_w_ena_o),
    .reg_w_addr_o(reg_w_addr_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // RISC-V M-extension result for one division.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return 32'($signed(a) / $signed(b));
      2'b01:   return a / b;
      2'b10:   return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Timeline model: an accepted request completes after a fixed number of
  // clocks (33 for a normal division, 1 for divide-by-zero/overflow).
  int          m_pend = 0;
  logic [31:0] m_pend_res = '0;
  logic [4:0]  m_pend_addr = '0;
  logic        m_ready = 1'b0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_addr = '0;
  bit          check_en = 1'b0;

  always @(posedge clk_100MHz) begin
    logic was_ready;
    if (rst) begin
      m_pend = 0; m_ready = 1'b0; m_res = '0; m_addr = '0;
    end else if (jump_ena_i) begin
      m_pend = 0; m_ready = 1'b0;
    end else begin
      was_ready = m_ready;
      m_ready = 1'b0;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          m_ready = 1'b1;
          m_res   = m_pend_res;
          m_addr  = m_pend_addr;
        end
      end else if (start_i && !was_ready) begin
        m_pend      = is_special(op_i, dividend_i, divisor_i) ? 1 : 33;
        m_pend_res  = ref_div(op_i, dividend_i, divisor_i);
        m_pend_addr = reg_w_addr_i;
      end
    end
  end

  always @(negedge clk_100MHz) begin
    if (check_en) begin
      chk("busy_o", 32'(busy_o), 32'(m_pend > 0));
      chk("ready_o", 32'(ready_o), 32'(m_ready));
      chk("reg_w_ena_o", 32'(reg_w_ena_o), 32'(m_ready));
      chk("div_hold_o", 32'(div_hold_o),
          32'((m_pend > 0) | (start_i & ~m_ready & ~jump_ena_i)));
      chk("result_o", result_o, m_res);
      chk("reg_w_addr_o", 32'(reg_w_addr_o), 32'(m_addr));
    end
  end

  task automatic cyc();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] addr);
    op_i = op; dividend_i = a; divisor_i = b; reg_w_addr_i = addr;
  endtask

  task automatic wait_ready(input string name, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk_100MHz);
      if (ready_o) begin seen = 1'b1; break; end
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr, input logic [31:0] exp);
    bit seen;
    drive(op, a, b, addr);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    wait_ready(name, seen);
    if (seen) begin
      chk(name, result_o, exp);
      chk({name, "_addr"}, 32'(reg_w_addr_o), 32'(addr));
      chk({name, "_hold"}, 32'(div_hold_o), 32'd0);
    end
    cyc();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int  pulses;
    bit  seen;
    logic [31:0] held;

    repeat (3) cyc();
    @(negedge clk_100MHz);
    chk("rst_result", result_o, 32'h0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_hold", 32'(div_hold_o), 32'd0);
    cyc();
    rst = 1'b0;
    check_en = 1'b1;
    cyc();

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd9, 32'd14);
    do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFF);
    do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFD);
    do_op("remu_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'd1);
    do_op("div_5_0", 2'b00, 32'd5, 32'd0, 5'd4, 32'hFFFF_FFFF);
    do_op("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd5, 32'd5);
    do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000);
    do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h0);

    // flush at iteration 10
    held = result_o;
    drive(2'b01, 32'd1000, 32'd3, 5'd10);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    repeat (10) cyc();
    jump_ena_i = 1'b1;
    cyc();
    jump_ena_i = 1'b0;
    @(negedge clk_100MHz);
    chk("flush_busy", 32'(busy_o), 32'd0);
    chk("flush_hold", 32'(div_hold_o), 32'd0);
    chk("flush_result", result_o, held);
    cyc();
    do_op("divu_9_3", 2'b01, 32'd9, 32'd3, 5'd11, 32'd3);

    // start held across completion
    drive(2'b01, 32'd50, 32'd5, 5'd12);
    start_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk_100MHz);
      if (ready_o) pulses++;
    end
    chk("held_pulses", 32'(pulses), 32'd1);
    chk("held_result", result_o, 32'd10);
    @(posedge clk_100MHz); #1;
    start_i = 1'b0;
    repeat (40) cyc();

    // start re-asserted mid-CALC with other operands
    drive(2'b01, 32'd1000, 32'd10, 5'd13);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    repeat (5) cyc();
    drive(2'b00, 32'd7, 32'd7, 5'd14);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    wait_ready("toggle", seen);
    if (seen) begin
      chk("toggle_result", result_o, 32'd100);
      chk("toggle_addr", 32'(reg_w_addr_o), 32'd13);
    end
    cyc();

    // reset at iteration 20
    drive(2'b00, 32'd12345, 32'd6, 5'd15);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    repeat (20) cyc();
    rst = 1'b1;
    cyc();
    @(negedge clk_100MHz);
    chk("mrst_result", result_o, 32'h0);
    chk("mrst_busy", 32'(busy_o), 32'd0);
    chk("mrst_ready", 32'(ready_o), 32'd0);
    chk("mrst_addr", 32'(reg_w_addr_o), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    do_op("div_100_m7", 2'b00, 32'd100, 32'hFFFF_FFF9, 5'd16, 32'hFFFF_FFF2);

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 250; n++) begin
      int w;
      repeat ($urandom_range(0, 2)) cyc();
      drive(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
            5'($urandom_range(0, 31)));
      start_i = 1'b1;
      repeat ($urandom_range(1, 3)) cyc();
      start_i = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 34)) cyc();
        jump_ena_i = 1'b1;
        cyc();
        jump_ena_i = 1'b0;
      end
      w = 0;
      while ((busy_o || ready_o) && w < 50) begin
        cyc();
        w++;
      end
      if (w >= 50) chk("rand_idle_timeout", 32'd0, 32'd1);
    end

    repeat (2) cyc();
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
